// File: rtl/timer_counter.sv
// Programmable down-counting timer with a bus-mapped CTRL/PRESET/COUNT register file and a masked interrupt.
// Define TIMER_AUTORELOAD_EN to enable the MODE=1 auto-reload behaviour.
module timer_counter (
  input  logic        clk,
  input  logic        reset,
  input  logic [1:0]  addr,
  input  logic        we,
  input  logic [3:0]  be,
  input  logic [31:0] din,
  output logic [31:0] dout,
  output logic        irq
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    LOAD = 2'd1,
    CNT  = 2'd2,
    INT  = 2'd3
  } state_t;

  state_t      state, state_n;
  logic        en, en_n;
  logic        im, im_n;
  logic [1:0]  mode;
  logic [31:0] preset, preset_n;
  logic [31:0] count, count_n;
  logic        pending, pending_n;
  logic        reload;

`ifdef TIMER_AUTORELOAD_EN
  logic [1:0] mode_n;

  always_comb begin
    mode_n = mode;
    if (we && addr == 2'd0 && be[0])
      mode_n = din[2:1];
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) mode <= '0;
    else       mode <= mode_n;
  end

  assign reload = (mode == 2'd1);
`else
  assign mode   = '0;
  assign reload = 1'b0;
`endif

  // FSM update first, then the bus write overrides it so software always wins on a shared edge.
  always_comb begin
    state_n   = state;
    en_n      = en;
    im_n      = im;
    preset_n  = preset;
    count_n   = count;
    pending_n = pending;

    case (state)
      IDLE: if (en) state_n = LOAD;
      LOAD: begin
        count_n   = preset;
        // only an auto-reload pass can arrive here with pending set
        pending_n = 1'b0;
        state_n   = CNT;
      end
      CNT: begin
        if (!en) begin
          state_n = IDLE;
        end else if (count > 32'd1) begin
          count_n = count - 32'd1;
        end else begin
          count_n = '0;
          state_n = INT;
        end
      end
      INT: begin
        pending_n = 1'b1;
        if (reload) begin
          state_n = LOAD;
        end else begin
          en_n    = 1'b0;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase

    if (we) begin
      case (addr)
        2'd0: begin
          pending_n = 1'b0;
          if (be[0]) begin
            en_n = din[0];
            im_n = din[3];
            if (!din[0]) state_n = IDLE;
          end
        end
        2'd1: begin
          for (int unsigned i = 0; i < 4; i++)
            if (be[i]) preset_n[8*i +: 8] = din[8*i +: 8];
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      en      <= 1'b0;
      im      <= 1'b0;
      preset  <= '0;
      count   <= '0;
      pending <= 1'b0;
      irq     <= 1'b0;
    end else begin
      state   <= state_n;
      en      <= en_n;
      im      <= im_n;
      preset  <= preset_n;
      count   <= count_n;
      pending <= pending_n;
      irq     <= pending_n & im_n;
    end
  end

  always_comb begin
    dout = '0;
    case (addr)
      2'd0:    dout = {28'd0, im, mode, en};
      2'd1:    dout = preset;
      2'd2:    dout = count;
      default: dout = '0;
    endcase
  end

endmodule

// File: tb/tb_timer_counter.sv
// Directed self-checking bench for timer_counter; inputs change and outputs are sampled on the falling clock edge.
module tb_timer_counter;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] din;
  logic [31:0] dout;
  logic        irq;

  int n_cmp = 0;
  int n_bad = 0;

  timer_counter dut (
    .clk  (clk),
    .reset(reset),
    .addr (addr),
    .we   (we),
    .be   (be),
    .din  (din),
    .dout (dout),
    .irq  (irq)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reg(input string tag, input logic [1:0] a, input logic [31:0] exp);
    addr = a;
    #1;
    chk(tag, dout, exp);
  endtask

  task automatic chk_irq(input string tag, input logic exp);
    chk(tag, {31'd0, irq}, {31'd0, exp});
  endtask

  task automatic chk_state(input string tag, input logic [1:0] exp);
    logic [1:0] st;
    st = dut.state;
    chk(tag, {30'd0, st}, {30'd0, exp});
  endtask

  // Drives the bus during the current low phase; the write lands on the next rising edge.
  task automatic wr(input logic [1:0] a, input logic [31:0] d, input logic [3:0] b);
    addr = a; din = d; be = b; we = 1'b1;
    @(negedge clk);
    we = 1'b0; be = 4'h0; din = '0;
  endtask

  task automatic step(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    reset = 1'b1; addr = 2'd0; we = 1'b0; be = 4'h0; din = '0;
    #1;
    chk_irq("rst_irq", 1'b0);
    chk_reg("rst_ctrl", 2'd0, 32'h0);
    chk_reg("rst_preset", 2'd1, 32'h0);
    chk_reg("rst_count", 2'd2, 32'h0);
    chk_reg("rst_rsvd", 2'd3, 32'h0);
    chk_state("rst_state", 2'd0);
    @(negedge clk);
    reset = 1'b0;
    step(1);

    // Reset pulse in the middle of a count
    wr(2'd1, 32'd8, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    step(2);
    chk_reg("mid_cnt8", 2'd2, 32'd8);
    step(3);
    chk_reg("mid_cnt5", 2'd2, 32'd5);
    #2 reset = 1'b1;
    #1;
    chk_irq("async_irq", 1'b0);
    chk_reg("async_ctrl", 2'd0, 32'h0);
    chk_reg("async_preset", 2'd1, 32'h0);
    chk_reg("async_count", 2'd2, 32'h0);
    chk_reg("async_rsvd", 2'd3, 32'h0);
    chk_state("async_state", 2'd0);
    @(negedge clk);
    reset = 1'b0;
    step(3);
    chk_state("post_rst_idle", 2'd0);
    chk_reg("post_rst_count", 2'd2, 32'h0);

    // One-shot, PRESET=3, IM=1
    wr(2'd1, 32'd3, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    chk_reg("os_ctrl", 2'd0, 32'h9);
    step(2);
    chk_reg("os_c3", 2'd2, 32'd3);
    step(1);
    chk_reg("os_c2", 2'd2, 32'd2);
    step(1);
    chk_reg("os_c1", 2'd2, 32'd1);
    step(1);
    chk_reg("os_c0", 2'd2, 32'd0);
    chk_irq("os_irq_lo", 1'b0);
    step(1);
    chk_irq("os_irq_hi", 1'b1);
    chk_reg("os_ctrl_en_clr", 2'd0, 32'h8);
    step(4);
    chk_irq("os_irq_held", 1'b1);
    chk_reg("os_count_held", 2'd2, 32'd0);
    wr(2'd0, 32'h8, 4'hF);
    chk_irq("os_irq_cleared", 1'b0);

    // Masked completion, then unmasking with nothing pending
    wr(2'd1, 32'd1, 4'hF);
    wr(2'd0, 32'h1, 4'hF);
    step(4);
    chk_reg("mask_ctrl", 2'd0, 32'h0);
    chk_irq("mask_irq", 1'b0);
    wr(2'd0, 32'h8, 4'hF);
    step(1);
    chk_irq("mask_unmask_irq", 1'b0);
    chk_reg("mask_ctrl8", 2'd0, 32'h8);

    // Byte lanes, read-only/reserved writes, upper CTRL bits
    wr(2'd1, 32'h0, 4'hF);
    wr(2'd1, 32'hAABBCCDD, 4'b0101);
    chk_reg("be_preset", 2'd1, 32'h00BB00DD);
    wr(2'd2, 32'h1234, 4'hF);
    chk_reg("count_ro", 2'd2, 32'h0);
    wr(2'd3, 32'hFFFFFFFF, 4'hF);
    chk_reg("rsvd_ro", 2'd3, 32'h0);
    wr(2'd0, 32'hFFFFFFF8, 4'hF);
    chk_reg("ctrl_hi_ign", 2'd0, 32'h8);

    // PRESET=0 reaches INT one cycle after LOAD
    wr(2'd1, 32'h0, 4'hF);
    wr(2'd0, 32'h9, 4'hF);
    step(1);
    chk_state("p0_load", 2'd1);
    step(2);
    chk_state("p0_int", 2'd3);
    chk_reg("p0_count", 2'd2, 32'h0);
    step(1);
    chk_irq("p0_irq", 1'b1);
    wr(2'd0, 32'h0, 4'hF);
    chk_irq("p0_irq_clr", 1'b0);
    chk_state("p0_idle", 2'd0);

`ifdef TIMER_AUTORELOAD_EN
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    chk_reg("ar_ctrl", 2'd0, 32'hB);
    step(2);
    for (int k = 0; k < 2; k++) begin
      chk_reg("ar_c2", 2'd2, 32'd2);
      chk_irq("ar_irq0", 1'b0);
      step(1);
      chk_reg("ar_c1", 2'd2, 32'd1);
      chk_irq("ar_irq1", 1'b0);
      step(1);
      chk_reg("ar_c0", 2'd2, 32'd0);
      chk_irq("ar_irq2", 1'b0);
      step(1);
      chk_irq("ar_pulse", 1'b1);
      step(1);
    end
    wr(2'd0, 32'h0, 4'hF);
    chk_irq("ar_stop", 1'b0);
`else
    wr(2'd1, 32'd2, 4'hF);
    wr(2'd0, 32'hB, 4'hF);
    chk_reg("na_ctrl", 2'd0, 32'h9);
    step(2);
    chk_reg("na_c2", 2'd2, 32'd2);
    step(2);
    chk_reg("na_c0", 2'd2, 32'd0);
    step(1);
    chk_irq("na_irq", 1'b1);
    chk_reg("na_ctrl_clr", 2'd0, 32'h8);
    step(3);
    chk_reg("na_no_reload", 2'd2, 32'd0);
    chk_irq("na_irq_held", 1'b1);
    wr(2'd0, 32'h8, 4'hF);
    chk_irq("na_irq_clr", 1'b0);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/timer_counter.md
TIMER_COUNTER -- requirements
Module: timer_counter

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset, with ports named as follows:
- clk  input  1  rising-edge clock shared with the processor pipeline.
- reset  input  1  asynchronous, active-high reset.
REQ-002 The block SHALL have the following further ports:
- addr  input  2  word select taken from processor address bits [3:2].
- we  input  1  write strobe from the processor bus.
- be  input  4  byte enables; bit i covers din[8i+7:8i].
- din  input  32  write data.
- dout  output  32  read data for the addressed register.
- irq  output  1  interrupt request, feeds one HWInt line.

Function
REQ-003 The block SHALL implement this register map:
- addr 0: CTRL. Bit0 EN (enable), bits[2:1] MODE, bit3 IM (interrupt mask). Bits[31:4] read 0.
- addr 1: PRESET, read/write.
- addr 2: COUNT, read-only.
- addr 3: reserved, reads 0.
REQ-004 dout SHALL be combinational from addr, with zero-cycle read latency.
REQ-005 A write SHALL update only the byte lanes whose be bit is set, at the rising edge on which we=1.
REQ-006 Writes to COUNT, to the reserved address, and to CTRL bits[31:4] SHALL be ignored.
REQ-007 The block SHALL use a 2-bit state machine with states IDLE, LOAD, CNT and INT.
REQ-008 IDLE -> LOAD on the edge after EN is 1.
REQ-009 LOAD: COUNT <= PRESET; next state CNT.
REQ-010 CNT:
- if EN=0, go to IDLE with COUNT held;
- else if COUNT > 1, COUNT <= COUNT-1;
- else COUNT <= 0 and go to INT.
- PRESET=0 therefore reaches INT one cycle after LOAD.
REQ-011 INT, MODE=0 (one-shot): clear EN, set the irq_pending flag, go to IDLE.
REQ-012 INT, MODE=1 (auto-reload): set irq_pending for one cycle only, go to LOAD.
REQ-013 MODE values 2 and 3 SHALL behave as MODE 0.
REQ-014 irq SHALL equal irq_pending AND IM, driven from a register (glitch-free).
REQ-015 In MODE 0, irq_pending SHALL remain set until any CTRL write, which clears it on that edge.
REQ-016 When a bus write to CTRL coincides with an FSM update of EN, the bus write SHALL win.
REQ-017 A PRESET write during CNT SHALL NOT alter COUNT until the next LOAD.
REQ-018 A CTRL write with EN=0 SHALL force state IDLE on that edge, from any state.
REQ-019 Counting SHALL be unsigned 32-bit; a COUNT of 0 never wraps to 0xFFFFFFFF.

Reset
REQ-020 On reset assertion, without waiting for a clock edge:
- CTRL, PRESET, COUNT and irq_pending SHALL go to 0;
- state SHALL go to IDLE;
- irq and dout SHALL be 0 for every addr.
REQ-021 Reset asserted mid-count SHALL abandon the count; after release the block stays in IDLE until EN is written.

Configuration
REQ-022 With macro TIMER_AUTORELOAD_EN defined, MODE=1 auto-reload SHALL be present as specified in REQ-012.
REQ-023 Without TIMER_AUTORELOAD_EN:
- CTRL bits[2:1] SHALL read 0 and ignore writes;
- all counting SHALL be one-shot per REQ-011.

Verification
REQ-024 Reset scenario: reset pulse mid-count with COUNT=5 -> COUNT=0, irq=0, dout=0 at all four addresses, state IDLE.
REQ-025 One-shot scenario: PRESET=3, then CTRL=0x9 -> COUNT reads 3, 2, 1, 0 on successive cycles; irq rises the cycle after 0 and stays high; CTRL reads 0x8; a later CTRL write of 0x8 drops irq.
REQ-026 Auto-reload scenario (macro defined): PRESET=2, CTRL=0xB -> irq single-cycle pulses every 4 cycles; COUNT sequence 2, 1, 0, 2, 1, 0...
REQ-027 Mask scenario: PRESET=1, CTRL=0x1 (IM=0) -> count completes and EN clears, irq stays 0; then CTRL=0x8 with no count running -> irq stays 0.
REQ-028 Byte-enable and boundary scenario:
- PRESET write din=0xAABBCCDD with be=0b0101 over PRESET=0 -> PRESET reads 0x00BB00DD.
- PRESET=0 with EN=1 -> INT reached one cycle after LOAD.
- Write 0x1234 to COUNT -> ignored.
REQ-029 Macro-absent scenario: CTRL=0xB -> CTRL reads 0x9; block behaves as one-shot.
